// File: rtl/svc_rv_fmem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : svc_rv_fmem_pkg
// Purpose  : Shared content-mode constants and address indexing for the
//            svc_rv memory timing/content model.
// Revision : 1.0 - initial release
// ============================================================================
package svc_rv_fmem_pkg;

  localparam int FMEM_ROM  = 0;
  localparam int FMEM_RAM  = 1;
  localparam int FMEM_RAND = 2;

  // Word index of a byte address; upper bits wrap modulo the store size.
  function automatic logic [31:0] fmem_idx(input logic [31:0] addr, input int unsigned words);
    return (addr >> 2) & (words - 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/svc_rv_fmem_if.sv
`default_nettype none
// ============================================================================
// Module   : svc_rv_fmem_if
// Purpose  : Core-side memory port bundle (read, write and stall signals).
// Revision : 1.0 - initial release
// ============================================================================
interface svc_rv_fmem_if #(
  parameter int DW = 32
) ();

  logic            ren;
  logic [31:0]     raddr;
  logic [DW-1:0]   rdata;
  logic            rvalid;
  logic            we;
  logic [31:0]     waddr;
  logic [DW-1:0]   wdata;
  logic [DW/8-1:0] wstrb;
  logic            stall;

  modport master (
    output ren, raddr, we, waddr, wdata, wstrb,
    input  rdata, rvalid, stall
  );

  modport slave (
    input  ren, raddr, we, waddr, wdata, wstrb,
    output rdata, rvalid, stall
  );

endinterface
`default_nettype wire

// File: rtl/svc_rv_fmem_pipe.sv
`default_nettype none
// ============================================================================
// Module   : svc_rv_fmem_pipe
// Purpose  : Freezable valid/data delay line providing the read latency.
// Revision : 1.0 - initial release
// ============================================================================
module svc_rv_fmem_pipe #(
  parameter int DEPTH = 1,
  parameter int DW    = 32
) (
  input  wire           clock,
  input  wire           reset,
  input  wire           en,
  input  wire           in_valid,
  input  wire  [DW-1:0] in_data,
  output logic          out_valid,
  output logic [DW-1:0] out_data
);

  logic [DEPTH-1:0] r_valid;
  logic [DW-1:0]    r_data [DEPTH];

  always_ff @(posedge clock) begin
    if (reset) begin
      r_valid <= '0;
    end else if (en) begin
      r_valid[0] <= in_valid;
      for (int k = 1; k < DEPTH; k++) begin
        r_valid[k] <= r_valid[k-1];
      end
    end
  end

  // Data only moves alongside a valid bit; empty slots keep stale contents.
  always_ff @(posedge clock) begin
    if (en) begin
      if (in_valid) begin
        r_data[0] <= in_data;
      end
      for (int k = 1; k < DEPTH; k++) begin
        if (r_valid[k-1]) begin
          r_data[k] <= r_data[k-1];
        end
      end
    end
  end

  assign out_valid = r_valid[DEPTH-1];
  assign out_data  = r_data[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/svc_rv_fmem.sv
`default_nettype none
// ============================================================================
// Module   : svc_rv_fmem_model
// Purpose  : Memory timing/content model (ROM/RAM/random data, 0..4 cycle
//            read latency, optional stall injection) for svc_rv harnesses.
// Revision : 1.0 - initial release
// ============================================================================
module svc_rv_fmem_model
  import svc_rv_fmem_pkg::*;
#(
  parameter int            DW         = 32,
  parameter int            WORDS      = 32,
  parameter int            LATENCY    = 1,
  parameter int            MODE       = 0,
  parameter int            STALL_EN   = 0,
  parameter logic [DW-1:0] RESET_DATA = DW'(32'h00000013)
) (
  input  wire                  clock,
  input  wire                  reset,
  input  wire  [WORDS*DW-1:0]  init_data,
  input  wire  [DW-1:0]        rand_rdata,
  input  wire                  stall_rand,
  svc_rv_fmem_if.slave         mem,
  output logic [7:0]           rd_issued
);

  localparam int c_AW = $clog2(WORDS);

  logic            w_stall;
  logic            w_acc;
  logic [c_AW-1:0] w_ridx;
  logic [DW-1:0]   w_src;
  logic [7:0]      r_rd_issued;
  logic            w_unused_ok;

  assign w_stall   = (STALL_EN != 0) && stall_rand;
  assign w_acc     = mem.ren && !w_stall;
  assign w_ridx    = c_AW'(fmem_idx(mem.raddr, WORDS));
  assign mem.stall = w_stall;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_rd_issued <= 8'd0;
    end else if (w_acc) begin
      r_rd_issued <= r_rd_issued + 8'd1;
    end
  end

  assign rd_issued = r_rd_issued;

  // Content source sampled at accept time.
  if (MODE == FMEM_RAM) begin : g_ram
    logic [DW-1:0]   r_store [WORDS];
    logic [c_AW-1:0] w_widx;

    assign w_widx = c_AW'(fmem_idx(mem.waddr, WORDS));

    always_ff @(posedge clock) begin
      if (reset) begin
        for (int i = 0; i < WORDS; i++) begin
          r_store[i] <= init_data[i*DW +: DW];
        end
      end else if (mem.we && !w_stall) begin
        for (int b = 0; b < DW/8; b++) begin
          if (mem.wstrb[b]) begin
            r_store[w_widx][b*8 +: 8] <= mem.wdata[b*8 +: 8];
          end
        end
      end
    end

    // Combinational read of the current array gives read-before-write.
    assign w_src = r_store[w_ridx];
  end else if (MODE == FMEM_ROM) begin : g_rom
    assign w_src = init_data[w_ridx*DW +: DW];
  end else begin : g_rand
    assign w_src = rand_rdata;
  end

  if (LATENCY == 0) begin : g_comb
    logic [DW-1:0] r_shadow;

    always_ff @(posedge clock) begin
      if (reset) begin
        r_shadow <= RESET_DATA;
      end else if (w_acc) begin
        r_shadow <= w_src;
      end
    end

    assign mem.rvalid = w_acc;
    assign mem.rdata  = w_acc ? w_src : r_shadow;
  end else begin : g_pipe
    logic          w_pvalid;
    logic [DW-1:0] w_pdata;
    logic          w_en;
    logic [DW-1:0] r_hold;

    assign w_en = !w_stall;

    svc_rv_fmem_pipe #(
      .DEPTH (LATENCY),
      .DW    (DW)
    ) u_pipe (
      .clock     (clock),
      .reset     (reset),
      .en        (w_en),
      .in_valid  (w_acc),
      .in_data   (w_src),
      .out_valid (w_pvalid),
      .out_data  (w_pdata)
    );

    // Last delivered word, presented whenever no read is completing.
    always_ff @(posedge clock) begin
      if (reset) begin
        r_hold <= RESET_DATA;
      end else if (w_pvalid && w_en) begin
        r_hold <= w_pdata;
      end
    end

    assign mem.rvalid = w_pvalid;
    assign mem.rdata  = w_pvalid ? w_pdata : r_hold;
  end

  assign w_unused_ok = ^{mem.we, mem.waddr, mem.wdata, mem.wstrb,
                         init_data, rand_rdata, stall_rand};

endmodule
`default_nettype wire

// File: tb/tb_svc_rv_fmem_model.sv
`default_nettype none
// ============================================================================
// Module   : tb_svc_rv_fmem_model
// Purpose  : Scoreboard bench for three model configurations (RAM/L2/stall,
//            ROM/L0, RAND/L3/stall) driven by shared random stimulus.
// Revision : 1.0 - initial release
// ============================================================================
module tb_svc_rv_fmem_model;
  import svc_rv_fmem_pkg::*;

  typedef struct packed {
    logic [31:0] data;
    logic [31:0] due;
  } exp_t;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset_c      = 1'b1;
  logic        ren_c        = 1'b0;
  logic [31:0] raddr_c      = '0;
  logic        we_c         = 1'b0;
  logic [31:0] waddr_c      = '0;
  logic [31:0] wdata_c      = '0;
  logic [3:0]  wstrb_c      = '0;
  logic        stall_rand_c = 1'b0;
  logic [31:0] rand_c       = '0;

  logic [8*32-1:0]  init0;
  logic [32*32-1:0] init1;
  logic [32*32-1:0] init2 = '0;
  logic [7:0]       iss0, iss1, iss2;

  svc_rv_fmem_if #(.DW(32)) m0 ();
  svc_rv_fmem_if #(.DW(32)) m1 ();
  svc_rv_fmem_if #(.DW(32)) m2 ();

  assign m0.ren = ren_c;  assign m0.raddr = raddr_c;  assign m0.we = we_c;
  assign m0.waddr = waddr_c;  assign m0.wdata = wdata_c;  assign m0.wstrb = wstrb_c;
  assign m1.ren = ren_c;  assign m1.raddr = raddr_c;  assign m1.we = we_c;
  assign m1.waddr = waddr_c;  assign m1.wdata = wdata_c;  assign m1.wstrb = wstrb_c;
  assign m2.ren = ren_c;  assign m2.raddr = raddr_c;  assign m2.we = we_c;
  assign m2.waddr = waddr_c;  assign m2.wdata = wdata_c;  assign m2.wstrb = wstrb_c;

  svc_rv_fmem_model #(.DW(32), .WORDS(8), .LATENCY(2), .MODE(FMEM_RAM), .STALL_EN(1)) u_dut0 (
    .clock(clock), .reset(reset_c), .init_data(init0), .rand_rdata(rand_c),
    .stall_rand(stall_rand_c), .mem(m0), .rd_issued(iss0));
  svc_rv_fmem_model #(.DW(32), .WORDS(32), .LATENCY(0), .MODE(FMEM_ROM), .STALL_EN(0)) u_dut1 (
    .clock(clock), .reset(reset_c), .init_data(init1), .rand_rdata(rand_c),
    .stall_rand(stall_rand_c), .mem(m1), .rd_issued(iss1));
  svc_rv_fmem_model #(.DW(32), .WORDS(32), .LATENCY(3), .MODE(FMEM_RAND), .STALL_EN(1)) u_dut2 (
    .clock(clock), .reset(reset_c), .init_data(init2), .rand_rdata(rand_c),
    .stall_rand(stall_rand_c), .mem(m2), .rd_issued(iss2));

  logic        rv_a  [3];
  logic [31:0] rd_a  [3];
  logic [7:0]  iss_a [3];
  logic        st_a  [3];
  assign rv_a[0] = m0.rvalid;  assign rd_a[0] = m0.rdata;  assign iss_a[0] = iss0;  assign st_a[0] = m0.stall;
  assign rv_a[1] = m1.rvalid;  assign rd_a[1] = m1.rdata;  assign iss_a[1] = iss1;  assign st_a[1] = m1.stall;
  assign rv_a[2] = m2.rvalid;  assign rd_a[2] = m2.rdata;  assign iss_a[2] = iss2;  assign st_a[2] = m2.stall;

  // Reference model state
  exp_t        sb [3][$];
  logic [31:0] active [3];
  logic [7:0]  cnt [3];
  logic [31:0] last [3];
  logic        prev_acc [3];
  logic        prev_stall [3];
  logic        prev_rst = 1'b1;
  logic [31:0] store0 [8];
  logic [31:0] rom1 [32];

  int checks   = 0;
  int failures = 0;

  function automatic int lat_of(input int d);
    return (d == 0) ? 2 : ((d == 1) ? 0 : 3);
  endfunction

  function automatic logic se_of(input int d);
    return d != 1;
  endfunction

  // One clock of stimulus; expected responses are queued at accept time.
  task automatic step(input logic rn, input logic [31:0] ra, input logic w,
                      input logic [31:0] wa, input logic [31:0] wd, input logic [3:0] ws,
                      input logic sr, input logic [31:0] rr, input logic rs);
    logic [31:0] src;
    logic        st;
    logic        acc;
    exp_t        e;
    int          wi;
    @(posedge clock);
    #1;
    for (int d = 0; d < 3; d++) begin
      if (!prev_stall[d]) active[d] = active[d] + 32'd1;
      if (prev_rst) cnt[d] = 8'd0;
      else if (prev_acc[d]) cnt[d] = cnt[d] + 8'd1;
    end
    if (prev_rst) for (int i = 0; i < 8; i++) store0[i] = init0[i*32 +: 32];
    reset_c = rs;  ren_c = rn & ~rs;  raddr_c = ra;  we_c = w;  waddr_c = wa;
    wdata_c = wd;  wstrb_c = ws;  stall_rand_c = sr;  rand_c = rr;
    for (int d = 0; d < 3; d++) begin
      st  = se_of(d) && sr;
      acc = rn && !st && !rs;
      case (d)
        0:       src = store0[(ra / 4) % 8];
        1:       src = rom1[(ra / 4) % 32];
        default: src = rr;
      endcase
      if (acc) begin
        e.data = src;
        e.due  = active[d] + 32'(lat_of(d));
        sb[d].push_back(e);
      end
      prev_acc[d]   = acc;
      prev_stall[d] = st;
    end
    if (w && !sr && !rs) begin
      wi = int'((wa / 4) % 8);
      for (int b = 0; b < 4; b++) if (ws[b]) store0[wi][b*8 +: 8] = wd[b*8 +: 8];
    end
    prev_rst = rs;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, '0, '0, 4'h0, 1'b0, '0, 1'b0);
  endtask

  task automatic rd(input logic [31:0] ra);
    step(1'b1, ra, 1'b0, '0, '0, 4'h0, 1'b0, 32'h0, 1'b0);
  endtask

  // Monitor: compares every DUT output against the scoreboard head.
  always @(negedge clock) begin
    logic exp_v;
    logic mst;
    for (int d = 0; d < 3; d++) begin
      if (reset_c) begin
        sb[d].delete();
        last[d] = 32'h00000013;
      end else begin
        mst   = se_of(d) && stall_rand_c;
        exp_v = (sb[d].size() > 0) && (sb[d][0].due <= active[d]);
        checks++;
        if (st_a[d] !== mst) begin
          failures++;
          $display("FAIL stall dut%0d got=%b exp=%b", d, st_a[d], mst);
        end
        checks++;
        if (rv_a[d] !== exp_v) begin
          failures++;
          $display("FAIL rvalid dut%0d got=%b exp=%b t=%0t", d, rv_a[d], exp_v, $time);
        end
        checks++;
        if (exp_v) begin
          if (rd_a[d] !== sb[d][0].data) begin
            failures++;
            $display("FAIL rdata dut%0d got=%h exp=%h t=%0t", d, rd_a[d], sb[d][0].data, $time);
          end
          if (!mst) begin
            last[d] = sb[d][0].data;
            void'(sb[d].pop_front());
          end
        end else if (rd_a[d] !== last[d]) begin
          failures++;
          $display("FAIL rdata_hold dut%0d got=%h exp=%h t=%0t", d, rd_a[d], last[d], $time);
        end
        checks++;
        if (iss_a[d] !== cnt[d]) begin
          failures++;
          $display("FAIL rd_issued dut%0d got=%0d exp=%0d t=%0t", d, iss_a[d], cnt[d], $time);
        end
      end
    end
  end

  initial begin
    logic [31:0] wv;
    for (int d = 0; d < 3; d++) begin
      active[d] = '0;  cnt[d] = '0;  last[d] = 32'h13;  prev_acc[d] = 1'b0;  prev_stall[d] = 1'b0;
    end
    for (int i = 0; i < 8; i++) begin
      wv = (i == 5) ? 32'hAAAAAAAA : $urandom;
      init0[i*32 +: 32] = wv;
    end
    for (int i = 0; i < 32; i++) begin
      wv = (i == 3) ? 32'hDEADBEEF : $urandom;
      init1[i*32 +: 32] = wv;
      rom1[i] = wv;
    end

    step(1'b0, '0, 1'b0, '0, '0, 4'h0, 1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b0, '0, '0, 4'h0, 1'b0, '0, 1'b1);
    idle(2);

    // Combinational ROM hit and address wrap
    rd(32'h0000000C);
    rd(32'h0000008C);
    idle(4);
    // Back-to-back reads
    rd(32'h0);  rd(32'h4);  rd(32'h8);
    idle(5);
    // Partial write with same-cycle read, then read-after-write
    step(1'b1, 32'h14, 1'b1, 32'h14, 32'h11223344, 4'b0101, 1'b0, '0, 1'b0);
    rd(32'h14);
    idle(5);
    // Stall after accept, ren held during the stall
    rd(32'h10);
    step(1'b1, 32'h10, 1'b0, '0, '0, 4'h0, 1'b1, '0, 1'b0);
    step(1'b1, 32'h10, 1'b0, '0, '0, 4'h0, 1'b1, '0, 1'b0);
    idle(5);
    // Reset one cycle after an accept
    rd(32'h18);
    step(1'b0, '0, 1'b0, '0, '0, 4'h0, 1'b0, '0, 1'b1);
    idle(2);
    rd(32'h14);
    idle(5);
    // Random data captured at accept, then changed
    step(1'b1, 32'h0, 1'b0, '0, '0, 4'h0, 1'b0, 32'hCAFEF00D, 1'b0);
    step(1'b0, 32'h0, 1'b0, '0, '0, 4'h0, 1'b0, 32'h12345678, 1'b0);
    idle(5);

    for (int i = 0; i < 3000; i++) begin
      step(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)), $urandom, $urandom,
           4'($urandom_range(0, 15)), ($urandom_range(0, 3) == 0), $urandom,
           ($urandom_range(0, 199) == 0));
    end
    idle(8);
    @(negedge clock);
    #1;
    for (int d = 0; d < 3; d++) begin
      checks++;
      if (sb[d].size() != 0) begin
        failures++;
        $display("FAIL drain dut%0d got=%0d pending exp=0", d, sb[d].size());
      end
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
